// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate datapath.
// Opcode encoding carried from the operand source into the MAC pipeline.
package mac_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_ACC  = 2'b01,
        OP_CLR  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

endpackage

// File: rtl/mac_sat_add.sv
// Combinational AW-bit adder with overflow detection and optional clamping.
// Works for two's complement or unsigned operands; reusable by any accumulator.
module mac_sat_add #(
    parameter int AW     = 24,
    parameter bit SIGNED = 0,
    parameter bit SAT    = 1
) (
    input  logic [AW-1:0] i_a,
    input  logic [AW-1:0] i_b,
    output logic [AW-1:0] o_sum,
    output logic          o_ovf
);

    logic [AW:0]   w_full;
    logic [AW-1:0] w_raw;

    // Clamp value chosen by the direction of the overflow (sign of the operands).
    function automatic logic [AW-1:0] sat_limit(input logic neg);
        if (!SIGNED)
            return '1;
        return neg ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    endfunction

    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    assign w_raw  = w_full[AW-1:0];

    always_comb begin
        o_ovf = 1'b0;
        if (SIGNED)
            o_ovf = (i_a[AW-1] == i_b[AW-1]) && (w_raw[AW-1] != i_a[AW-1]);
        else
            o_ovf = w_full[AW];
        o_sum = (SAT && o_ovf) ? sat_limit(i_a[AW-1]) : w_raw;
    end

endmodule

// File: rtl/mac_unit_param.sv
// Two-stage pipelined multiply-accumulate unit with valid/ready handshakes.
// Stage 1 forms the product; stage 2 owns the accumulator, so back-to-back ACC has no hazard.
module mac_unit_param
    import mac_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 24,
    parameter bit SIGNED = 0,
    parameter bit SAT    = 1
) (
    input  logic          CLK,
    input  logic          S,
    input  logic [1:0]    I,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic          IN_VALID,
    output logic          IN_READY,
    output logic [AW-1:0] Y,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic          OVF
);

    logic            w_en1;
    logic            w_en2;
    logic [2*DW-1:0] w_prod;
    logic [AW-1:0]   w_prod_ext;
    logic [AW-1:0]   w_sum;
    logic            w_add_ovf;

    logic            r_vld_p1;
    op_e             r_op_p1;
    logic [2*DW-1:0] r_prod_p1;

    logic [AW-1:0]   r_acc_p2;
    logic            r_ovf_p2;
    logic            r_vld_p2;

    // Low 2*DW bits of a 2*DW x 2*DW product are correct for both signednesses.
    function automatic logic [2*DW-1:0] ext_op(input logic [DW-1:0] v);
        return {{DW{SIGNED && v[DW-1]}}, v};
    endfunction

    function automatic logic [AW-1:0] ext_prod(input logic [2*DW-1:0] p);
        logic [AW-1:0] r;
        r            = {AW{SIGNED && p[2*DW-1]}};
        r[2*DW-1:0]  = p;
        return r;
    endfunction

    assign w_en2    = !r_vld_p2 || OUT_READY;
    assign w_en1    = !r_vld_p1 || w_en2;
    assign IN_READY = w_en1;
    assign w_prod   = ext_op(A) * ext_op(B);

    // ---- stage 1: op and product capture ----
    always_ff @(posedge CLK) begin
        if (!S)
            r_vld_p1 <= 1'b0;
        else if (w_en1)
            r_vld_p1 <= IN_VALID;
    end

    always_ff @(posedge CLK) begin
        if (w_en1 && IN_VALID) begin
            r_op_p1   <= op_e'(I);
            r_prod_p1 <= w_prod;
        end
    end

    assign w_prod_ext = ext_prod(r_prod_p1);

    mac_sat_add #(
        .AW     (AW),
        .SIGNED (SIGNED),
        .SAT    (SAT)
    ) u_add (
        .i_a   (r_acc_p2),
        .i_b   (w_prod_ext),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    // ---- stage 2: accumulator, sticky overflow and output valid ----
    always_ff @(posedge CLK) begin
        if (!S) begin
            r_acc_p2 <= '0;
            r_ovf_p2 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (w_en2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                case (r_op_p1)
                    OP_ACC: begin
                        r_acc_p2 <= w_sum;
                        if (w_add_ovf)
                            r_ovf_p2 <= 1'b1;
                    end
                    OP_CLR: begin
                        r_acc_p2 <= '0;
                        r_ovf_p2 <= 1'b0;
                    end
                    OP_LOAD: begin
                        r_acc_p2 <= w_prod_ext;
                        r_ovf_p2 <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Y         = r_acc_p2;
    assign OUT_VALID = r_vld_p2;
    assign OVF       = r_ovf_p2;

endmodule

// File: tb/tb_mac_unit_param.sv
// Bench for mac_unit_param: directed scenarios on several parameter sets plus
// randomized traffic scored against an arithmetic reference model.
module tb_mac_unit_param;
    import mac_pkg::*;

    logic       CLK = 1'b0;
    logic       S;
    logic [1:0] I;
    logic [7:0] A;
    logic [7:0] B;
    logic       IN_VALID;
    logic       OUT_READY;

    int total = 0;
    int bad   = 0;

    logic        rdy0, rdy1, rdy2, rdy3, rdy4;
    logic        vld0, vld1, vld2, vld3, vld4;
    logic        ovf0, ovf1, ovf2, ovf3, ovf4;
    logic [23:0] y0;
    logic [7:0]  y1;
    logic [15:0] y2;
    logic [15:0] y3;
    logic [23:0] y4;

    always #5 CLK = ~CLK;

    // u0: defaults; u1: 2-bit sweep; u2/u3: 16-bit saturate vs wrap; u4: signed
    mac_unit_param u0 (
        .CLK(CLK), .S(S), .I(I), .A(A), .B(B), .IN_VALID(IN_VALID), .IN_READY(rdy0),
        .Y(y0), .OUT_VALID(vld0), .OUT_READY(OUT_READY), .OVF(ovf0));

    mac_unit_param #(.DW(2), .AW(8), .SIGNED(0), .SAT(1)) u1 (
        .CLK(CLK), .S(S), .I(I), .A(A[1:0]), .B(B[1:0]), .IN_VALID(IN_VALID), .IN_READY(rdy1),
        .Y(y1), .OUT_VALID(vld1), .OUT_READY(OUT_READY), .OVF(ovf1));

    mac_unit_param #(.DW(8), .AW(16), .SIGNED(0), .SAT(1)) u2 (
        .CLK(CLK), .S(S), .I(I), .A(A), .B(B), .IN_VALID(IN_VALID), .IN_READY(rdy2),
        .Y(y2), .OUT_VALID(vld2), .OUT_READY(OUT_READY), .OVF(ovf2));

    mac_unit_param #(.DW(8), .AW(16), .SIGNED(0), .SAT(0)) u3 (
        .CLK(CLK), .S(S), .I(I), .A(A), .B(B), .IN_VALID(IN_VALID), .IN_READY(rdy3),
        .Y(y3), .OUT_VALID(vld3), .OUT_READY(OUT_READY), .OVF(ovf3));

    mac_unit_param #(.DW(8), .AW(24), .SIGNED(1), .SAT(1)) u4 (
        .CLK(CLK), .S(S), .I(I), .A(A), .B(B), .IN_VALID(IN_VALID), .IN_READY(rdy4),
        .Y(y4), .OUT_VALID(vld4), .OUT_READY(OUT_READY), .OVF(ovf4));

    // Reference model for u2, u3, u4: mathematical accumulator value and sticky flag.
    int     cfg_aw  [3] = '{16, 16, 24};
    bit     cfg_sgn [3] = '{0, 0, 1};
    bit     cfg_sat [3] = '{1, 0, 1};
    longint m_acc   [3];
    bit     m_ovf   [3];

    typedef struct {
        longint y0;
        longint y1;
        longint y2;
        bit     o0;
        bit     o1;
        bit     o2;
    } res_t;
    res_t q[$];

    function automatic void model_step(input int k, input logic [1:0] op,
                                       input logic [7:0] a, input logic [7:0] b);
        longint p, s, lo, hi, span;
        span = longint'(1) << cfg_aw[k];
        if (cfg_sgn[k]) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            lo = -(span / 2);
            hi = span / 2 - 1;
        end else begin
            p  = longint'(a) * longint'(b);
            lo = 0;
            hi = span - 1;
        end
        case (op)
            2'b01: begin
                s = m_acc[k] + p;
                if (s > hi || s < lo) begin
                    m_ovf[k] = 1'b1;
                    if (cfg_sat[k]) begin
                        s = (s > hi) ? hi : lo;
                    end else begin
                        s = s & (span - 1);
                        if (s > hi) s = s - span;
                    end
                end
                m_acc[k] = s;
            end
            2'b10: begin m_acc[k] = 0; m_ovf[k] = 1'b0; end
            2'b11: begin m_acc[k] = p; m_ovf[k] = 1'b0; end
            default: ;
        endcase
    endfunction

    function automatic logic [7:0] pick_operand();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 8'hFF;
        if (r == 1) return 8'h80;
        return 8'($urandom);
    endfunction

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        S = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1; I = OP_NOP; A = 8'd0; B = 8'd0;
        cyc(); cyc();
        total++;
        if (y0 !== 24'd0 || vld0 !== 1'b0 || ovf0 !== 1'b0) begin
            bad++; $display("FAIL reset_state y=%0d vld=%b ovf=%b want 0/0/0", y0, vld0, ovf0);
        end
        S = 1'b1; #1;
        total++;
        if ({rdy0, rdy1, rdy2, rdy3, rdy4} !== 5'b11111) begin
            bad++; $display("FAIL reset_ready got=%b want=11111", {rdy0, rdy1, rdy2, rdy3, rdy4});
        end
        I = OP_LOAD; A = 8'd3; B = 8'd4; IN_VALID = 1'b1;
        cyc();
        total++;
        if (vld0 !== 1'b0 || rdy0 !== 1'b1) begin
            bad++; $display("FAIL latency_early vld=%b rdy=%b want 0/1", vld0, rdy0);
        end
        I = OP_ACC; A = 8'd2; B = 8'd5;
        cyc();
        total++;
        if (y0 !== 24'd12 || vld0 !== 1'b1 || rdy0 !== 1'b1) begin
            bad++; $display("FAIL load_result y=%0d vld=%b rdy=%b want 12/1/1", y0, vld0, rdy0);
        end
        IN_VALID = 1'b0;
        cyc();
        total++;
        if (y0 !== 24'd22 || vld0 !== 1'b1) begin
            bad++; $display("FAIL acc_result y=%0d vld=%b want 22/1", y0, vld0);
        end
        cyc();
        total++;
        if (y0 !== 24'd22 || vld0 !== 1'b0 || rdy0 !== 1'b1) begin
            bad++; $display("FAIL bubble y=%0d vld=%b rdy=%b want 22/0/1", y0, vld0, rdy0);
        end
    endtask

    task automatic test_sweep();
        int     k = 0;
        int     run = 0;
        int     prev = 0;
        longint expv = 0;
        OUT_READY = 1'b1;
        I = OP_CLR; IN_VALID = 1'b1;
        cyc();
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                I = OP_ACC; A = 8'(a); B = 8'(b);
                cyc();
                if (k > 0) begin
                    expv = expv + prev;
                    if (vld1 === 1'b1) run++;
                    total++;
                    if (y1 !== 8'(expv)) begin
                        bad++; $display("FAIL sweep_step k=%0d got=%0d want=%0d", k, y1, expv);
                    end
                end
                prev = a * b;
                k++;
            end
        end
        IN_VALID = 1'b0;
        cyc();
        expv = expv + prev;
        if (vld1 === 1'b1) run++;
        total++;
        if (y1 !== 8'd36 || ovf1 !== 1'b0 || expv != 36) begin
            bad++; $display("FAIL sweep_final y=%0d ovf=%b want 36/0", y1, ovf1);
        end
        total++;
        if (run != 16) begin
            bad++; $display("FAIL sweep_valid_run got=%0d want=16", run);
        end
    endtask

    task automatic test_saturation_wrap();
        OUT_READY = 1'b1;
        I = OP_LOAD; A = 8'd255; B = 8'd255; IN_VALID = 1'b1;
        cyc();
        I = OP_ACC;
        cyc();
        total++;
        if (y2 !== 16'd65025 || y3 !== 16'd65025 || vld2 !== 1'b1 || vld3 !== 1'b1) begin
            bad++; $display("FAIL sat_load sat=%0d wrap=%0d want 65025", y2, y3);
        end
        I = OP_CLR;
        cyc();
        total++;
        if (y2 !== 16'd65535 || ovf2 !== 1'b1) begin
            bad++; $display("FAIL sat_clamp y=%0d ovf=%b want 65535/1", y2, ovf2);
        end
        total++;
        if (y3 !== 16'd64514 || ovf3 !== 1'b1) begin
            bad++; $display("FAIL wrap_sum y=%0d ovf=%b want 64514/1", y3, ovf3);
        end
        IN_VALID = 1'b0;
        cyc();
        total++;
        if (y2 !== 16'd0 || ovf2 !== 1'b0 || y3 !== 16'd0 || ovf3 !== 1'b0) begin
            bad++; $display("FAIL clr_ovf sat=%0d/%b wrap=%0d/%b want 0/0", y2, ovf2, y3, ovf3);
        end
    endtask

    task automatic test_signed();
        OUT_READY = 1'b1;
        I = OP_LOAD; A = 8'hFD; B = 8'd5; IN_VALID = 1'b1;
        cyc();
        I = OP_ACC; A = 8'd3; B = 8'd5;
        cyc();
        total++;
        if (y4 !== 24'hFFFFF1 || vld4 !== 1'b1) begin
            bad++; $display("FAIL signed_load y=%h vld=%b want fffff1/1", y4, vld4);
        end
        IN_VALID = 1'b0;
        cyc();
        total++;
        if (y4 !== 24'd0 || ovf4 !== 1'b0) begin
            bad++; $display("FAIL signed_acc y=%h ovf=%b want 0/0", y4, ovf4);
        end
    endtask

    task automatic test_backpressure();
        OUT_READY = 1'b1;
        I = OP_CLR; IN_VALID = 1'b1;
        cyc();
        IN_VALID = 1'b0;
        cyc(); cyc();
        total++;
        if (vld0 !== 1'b0 || y0 !== 24'd0) begin
            bad++; $display("FAIL bp_idle y=%0d vld=%b want 0/0", y0, vld0);
        end
        I = OP_ACC; A = 8'd1; B = 8'd1; IN_VALID = 1'b1; OUT_READY = 1'b0;
        cyc();
        total++;
        if (rdy0 !== 1'b1 || vld0 !== 1'b0) begin
            bad++; $display("FAIL bp_first rdy=%b vld=%b want 1/0", rdy0, vld0);
        end
        cyc();
        total++;
        if (rdy0 !== 1'b0 || vld0 !== 1'b1 || y0 !== 24'd1) begin
            bad++; $display("FAIL bp_stall rdy=%b vld=%b y=%0d want 0/1/1", rdy0, vld0, y0);
        end
        cyc();
        total++;
        if (rdy0 !== 1'b0 || vld0 !== 1'b1 || y0 !== 24'd1) begin
            bad++; $display("FAIL bp_hold rdy=%b vld=%b y=%0d want 0/1/1", rdy0, vld0, y0);
        end
        OUT_READY = 1'b1; #1;
        total++;
        if (rdy0 !== 1'b1) begin
            bad++; $display("FAIL bp_release rdy=%b want 1", rdy0);
        end
        cyc();
        total++;
        if (y0 !== 24'd2 || vld0 !== 1'b1) begin
            bad++; $display("FAIL bp_step2 y=%0d vld=%b want 2/1", y0, vld0);
        end
        cyc();
        total++;
        if (y0 !== 24'd3 || vld0 !== 1'b1) begin
            bad++; $display("FAIL bp_step3 y=%0d vld=%b want 3/1", y0, vld0);
        end
        S = 1'b0;
        cyc();
        total++;
        if (y0 !== 24'd0 || vld0 !== 1'b0 || ovf0 !== 1'b0) begin
            bad++; $display("FAIL midstream_reset y=%0d vld=%b ovf=%b want 0/0/0", y0, vld0, ovf0);
        end
        S = 1'b1; IN_VALID = 1'b0;
        cyc();
        total++;
        if (vld0 !== 1'b0 || y0 !== 24'd0) begin
            bad++; $display("FAIL flushed_op y=%0d vld=%b want 0/0", y0, vld0);
        end
    endtask

    task automatic test_random();
        res_t r;
        int   sel;
        S = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        cyc();
        S = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0;
            m_ovf[k] = 1'b0;
        end
        q.delete();
        for (int n = 0; n < 610; n++) begin
            if (n < 600) begin
                IN_VALID  = ($urandom_range(0, 9) < 7);
                OUT_READY = ($urandom_range(0, 9) < 7);
            end else begin
                IN_VALID  = 1'b0;
                OUT_READY = 1'b1;
            end
            sel = $urandom_range(0, 9);
            I = (sel < 7) ? OP_ACC : (sel == 7) ? OP_LOAD : (sel == 8) ? OP_CLR : OP_NOP;
            A = pick_operand();
            B = pick_operand();
            #1;
            if (vld2 === 1'b1 && OUT_READY) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand_extra_result n=%0d y=%0d", n, y2);
                end else begin
                    r = q.pop_front();
                    if (y2 !== 16'(r.y0) || ovf2 !== r.o0 || y3 !== 16'(r.y1) || ovf3 !== r.o1 ||
                        y4 !== 24'(r.y2) || ovf4 !== r.o2) begin
                        bad++;
                        $display("FAIL rand_result n=%0d got=%0d/%b %0d/%b %h/%b want=%0d/%b %0d/%b %h/%b",
                                 n, y2, ovf2, y3, ovf3, y4, ovf4,
                                 16'(r.y0), r.o0, 16'(r.y1), r.o1, 24'(r.y2), r.o2);
                    end
                end
            end
            if (IN_VALID && rdy2 === 1'b1) begin
                for (int k = 0; k < 3; k++) model_step(k, I, A, B);
                r.y0 = m_acc[0]; r.y1 = m_acc[1]; r.y2 = m_acc[2];
                r.o0 = m_ovf[0]; r.o1 = m_ovf[1]; r.o2 = m_ovf[2];
                q.push_back(r);
            end
            cyc();
        end
        total++;
        if (q.size() != 0 || vld2 !== 1'b0) begin
            bad++; $display("FAIL rand_drain left=%0d vld=%b want 0/0", q.size(), vld2);
        end
    endtask

    initial begin
        S = 1'b0; I = OP_NOP; A = 8'd0; B = 8'd0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        test_reset();
        test_sweep();
        test_saturation_wrap();
        test_signed();
        test_backpressure();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_unit_param.md
Name: mac_unit_param

Overview:
Parametrised, pipelined successor to the 2-bit MAC_Unit. It keeps the 2-bit opcode I and operands A/B, and generalises operand and accumulator width. It adds signed/unsigned arithmetic, optional saturation with a sticky overflow flag, and valid/ready handshakes with backpressure. It sits between the operand source and the result consumer in the datapath.

Parameters:
DW, 8, operand width of A and B.
AW, 24, accumulator and Y width; must satisfy AW >= 2*DW.
SIGNED, 0, 1 = A, B, product and accumulator are two's complement; 0 = unsigned.
SAT, 1, 1 = clamp on overflow; 0 = wrap modulo 2^AW.

Ports:
CLK  in  1  clock; all logic on the rising edge.
S  in  1  synchronous, active-low reset.
I  in  2  opcode: 00 NOP, 01 ACC, 10 CLR, 11 LOAD.
A  in  DW  operand A.
B  in  DW  operand B.
IN_VALID  in  1  I/A/B valid this cycle.
IN_READY  out  1  block can accept an op.
Y  out  AW  accumulator value.
OUT_VALID  out  1  Y holds the result of a completed op.
OUT_READY  in  1  consumer accepts the result.
OVF  out  1  sticky overflow flag.

Behaviour:
- Interface: one clock, CLK. Reset S is synchronous and active-low.
- Reset (S=0 at a rising edge): Y=0, OVF=0, OUT_VALID=0, stage-1 valid v1=0.
  - S overrides all other inputs.
  - In-flight ops are discarded.
  - IN_READY=1 from the first cycle after reset.
- Pipeline:
  - Stage 1 registers op, sign/zero-extended product P = A*B (2*DW bits) and v1.
  - Stage 2 updates the accumulator/Y, OUT_VALID and OVF.
- Enables:
  - en2 = !OUT_VALID | OUT_READY
  - en1 = !v1 | en2
  - IN_READY = en1 (combinational)
- An op is accepted when IN_VALID & IN_READY at a rising edge.
- Latency: an op accepted at edge t appears on Y with OUT_VALID=1 after edge t+1.
- Throughput: 1 op/cycle with no stalls.
- Stage-2 capture (when en2 & v1):
  - NOP: Y unchanged.
  - ACC: Y = Y + ext(P).
  - CLR: Y = 0, OVF = 0.
  - LOAD: Y = ext(P), OVF = 0.
  - Every case sets OUT_VALID=1.
- If en2 & !v1: OUT_VALID = 0.
- If !en2 (stall): Y, OUT_VALID and stage-1 registers hold. Nothing is lost or duplicated.
- Overflow on ACC:
  - Unsigned: carry out of bit AW-1.
  - Signed: operands have equal sign and the sum's sign differs.
  - On overflow, OVF is set and stays set until CLR, LOAD or reset.
  - SAT=1: Y clamps to 2^AW-1 (unsigned), or to 2^(AW-1)-1 / -2^(AW-1) (signed).
  - SAT=0: Y wraps.
- Boundary cases:
  - Back-to-back ACC uses the just-updated Y. The accumulator lives only in stage 2, so there is no hazard.
  - IN_VALID=0 inserts a bubble; Y is unchanged.
  - OUT_READY is ignored while OUT_VALID=0.
  - A and B are sampled only when the op is accepted.
  - CLR with OVF=1 clears both Y and OVF in the same edge.

Decomposition:
- Shared package mac_pkg holds the opcode constants OP_NOP=2'b00, OP_ACC=2'b01, OP_CLR=2'b10, OP_LOAD=2'b11.
- One sub-module, mac_sat_add: a combinational AW-bit add with SIGNED/SAT parameters that outputs sum and ovf. It is reusable by other accumulators.
- Multiplier and pipeline control stay in the top module.

Test Plan:
- Reset/latency (defaults, OUT_READY=1): hold S=0 for 2 cycles, then release and send LOAD A=3, B=4 followed by ACC A=2, B=5. Required: Y=12 with OUT_VALID one edge after LOAD acceptance, then Y=22. IN_READY=1 throughout.
- Full sweep (DW=2, AW=8, unsigned): ACC every A,B in 0..3 for 16 cycles after CLR. Required: final Y=36, OVF=0, OUT_VALID high for 16 consecutive cycles.
- Saturation (AW=16, SAT=1): LOAD 255*255, then ACC 255*255. Required: Y=65025 then Y=65535, OVF=1. A following CLR gives Y=0, OVF=0.
- Wrap (AW=16, SAT=0): same stimulus as saturation. Required: Y=130050 mod 65536 = 64514, OVF=1.
- Signed (SIGNED=1, DW=8, AW=24): LOAD A=8'hFD (-3), B=5, then ACC A=3, B=5. Required: Y=24'hFFFFF1, then Y=0.
- Backpressure/reset: hold OUT_READY=0 for 3 cycles while IN_VALID=1 with ACC 1*1.
  - Required: IN_READY falls after 2 accepted ops and no result is lost; after release Y steps 1, 2, 3.
  - Then assert S=0 mid-stream: next edge gives Y=0, OUT_VALID=0, OVF=0.
